// File: rtl/slc3_pkg.sv
// Shared types and constants for the SLC-3 memory-side blocks.
package slc3_pkg;

  typedef logic [15:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_t;

  localparam word_t IO_SW_HEX_ADDR = 16'hFFFF;

  // True when a word address falls inside a RAM of the given depth.
  function automatic logic in_ram(input word_t addr, input int unsigned depth);
    return ({16'h0000, addr} < depth);
  endfunction

endpackage

// File: rtl/slc3_sync_ram.sv
// Single-port RAM with synchronous read, shaped for FPGA block-RAM inference.
module slc3_sync_ram
  import slc3_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [15:0]   i_wdata,
  output logic [15:0]   o_rdata
);

  word_t r_mem [DEPTH];
  word_t r_q;

  // Read-first access: the read port returns the old word on a write cycle.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_q <= r_mem[i_addr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/slc3_mem_responder.sv
// Target end of the SLC-3 CPU memory handshake: RAM plus switch/hex I/O at IO_ADDR,
// with a programmable number of wait states between acceptance and mem_rdy.
module slc3_mem_responder
  import slc3_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 2,
  parameter word_t       IO_ADDR     = IO_SW_HEX_ADDR
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_rdy,
  input  logic [9:0]  SW,
  output logic [15:0] hex_data,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH);

  resp_state_t r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  word_t       r_addr;
  word_t       r_wdata;
  logic        r_rdy;
  logic        r_err;
  logic [9:0]  r_sw;
  word_t       r_hex;

  logic [AW-1:0] w_ram_addr;
  logic          w_ram_we;
  word_t         w_ram_q;
  word_t         w_rdata;

  // The RAM is addressed straight from the bus in IDLE so the word is ready
  // even when RESP follows acceptance immediately.
  assign w_ram_addr = (r_state == IDLE) ? mem_addr[AW-1:0] : r_addr[AW-1:0];
  assign w_ram_we   = (r_state == RESP) && r_we && in_ram(r_addr, DEPTH) && !Reset;

  slc3_sync_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk   (Clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_q)
  );

  // Handshake FSM, request capture, wait counter, error flag and I/O registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 16'h0000;
      r_wdata <= 16'h0000;
      r_rdy   <= 1'b0;
      r_err   <= 1'b0;
      r_sw    <= 10'd0;
      r_hex   <= 16'h0000;
    end else begin
      r_rdy <= 1'b0;
      if (r_state != RESP) begin
        r_sw <= SW;
      end
      case (r_state)
        IDLE: begin
          if (mem_req) begin
            r_we    <= mem_we;
            r_addr  <= mem_addr;
            r_wdata <= mem_wdata;
            r_cnt   <= 4'(WAIT_STATES);
            if (WAIT_STATES == 32'd0) begin
              r_state <= RESP;
              r_rdy   <= 1'b1;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!mem_req) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_err   <= 1'b1;
          end else begin
            // Bus changes mid-wait are flagged; the captured request still completes.
            if ((mem_we != r_we) || (mem_addr != r_addr)) begin
              r_err <= 1'b1;
            end
            if (r_cnt == 4'd1) begin
              r_state <= RESP;
              r_rdy   <= 1'b1;
            end
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          r_state <= IDLE;
          if (r_we && (r_addr == IO_ADDR)) begin
            r_hex <= r_wdata;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Read decode on the captured address; zero outside the response cycle.
  always_comb begin
    w_rdata = 16'h0000;
    if (!r_rdy) begin
      w_rdata = 16'h0000;
    end else if (in_ram(r_addr, DEPTH)) begin
      w_rdata = w_ram_q;
    end else if (r_addr == IO_ADDR) begin
      w_rdata = {6'b000000, r_sw};
    end else begin
      w_rdata = 16'h0000;
    end
  end

  assign mem_rdata = w_rdata;
  assign mem_rdy   = r_rdy;
  assign hex_data  = r_hex;
  assign err       = r_err;

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Self-checking bench for slc3_mem_responder: table of transfers with a response
// scoreboard, plus hand sequences for abort, bus change, reset and back-to-back.
module tb_slc3_mem_responder;

  localparam int WS = 2;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [9:0]  sw;
    logic [15:0] exp_rdata;
    logic [15:0] exp_hex;
  } vec_t;

  typedef struct {
    logic        chk;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
  } op_t;

  logic        clk = 1'b0;
  logic        Reset;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, hex_data;
  logic        mem_rdy, err;
  logic [9:0]  SW;

  logic        req0, we0, rdy0, err0;
  logic [15:0] addr0, wdata0, rdata0, hex0;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];
  vec_t vecs[15];
  op_t  ops[4];

  always #5 clk = ~clk;

  slc3_mem_responder #(.DEPTH(256), .WAIT_STATES(WS), .IO_ADDR(16'hFFFF)) u_dut (
    .Clk(clk), .Reset(Reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy), .SW(SW),
    .hex_data(hex_data), .err(err)
  );

  slc3_mem_responder #(.DEPTH(256), .WAIT_STATES(0), .IO_ADDR(16'hFFFF)) u_dut0 (
    .Clk(clk), .Reset(Reset), .mem_req(req0), .mem_we(we0), .mem_addr(addr0),
    .mem_wdata(wdata0), .mem_rdata(rdata0), .mem_rdy(rdy0), .SW(SW),
    .hex_data(hex0), .err(err0)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Called at a negedge; one complete transfer on the WS=2 instance.
  task automatic xfer(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                      input logic [9:0] sw, input logic [15:0] exp_rd, input logic [15:0] exp_hex);
    exp_t e;
    int   lat;
    logic got;
    SW = sw; mem_we = we; mem_addr = addr; mem_wdata = wdata; mem_req = 1'b1;
    e.chk = !we; e.data = exp_rd;
    sb_q.push_back(e);
    @(posedge clk);
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk("rdata_zero_in_wait", {16'h0000, mem_rdata}, 32'd0);
      if (mem_rdy) got = 1'b1;
    end
    chk("latency", lat, WS + 1);
    e = sb_q.pop_front();
    if (got && e.chk) chk("rdata", {16'h0000, mem_rdata}, {16'h0000, e.data});
    @(posedge clk); #1;
    mem_req = 1'b0;
    @(negedge clk);
    chk("rdy_one_cycle", {31'd0, mem_rdy}, 32'd0);
    chk("hex", {16'h0000, hex_data}, {16'h0000, exp_hex});
  endtask

  task automatic do_reset();
    @(negedge clk);
    Reset = 1'b1; mem_req = 1'b0; req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    Reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    int rdy_cnt;
    Reset = 1'b1; mem_req = 1'b0; mem_we = 1'b0; mem_addr = 16'h0000; mem_wdata = 16'h0000;
    SW = 10'd0; req0 = 1'b0; we0 = 1'b0; addr0 = 16'h0000; wdata0 = 16'h0000;

    vecs[0]  = '{1'b1, 16'h0010, 16'h1234, 10'h000, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b0, 16'h0010, 16'h0000, 10'h000, 16'h1234, 16'h0000};
    vecs[2]  = '{1'b0, 16'hFFFF, 16'h0000, 10'h003, 16'h0003, 16'h0000};
    vecs[3]  = '{1'b1, 16'hFFFF, 16'hBEEF, 10'h003, 16'h0000, 16'hBEEF};
    vecs[4]  = '{1'b0, 16'hFFFF, 16'h0000, 10'h2A5, 16'h02A5, 16'hBEEF};
    vecs[5]  = '{1'b0, 16'h8000, 16'h0000, 10'h3FF, 16'h0000, 16'hBEEF};
    vecs[6]  = '{1'b1, 16'h0000, 16'hAAAA, 10'h000, 16'h0000, 16'hBEEF};
    vecs[7]  = '{1'b1, 16'h8000, 16'h5555, 10'h000, 16'h0000, 16'hBEEF};
    vecs[8]  = '{1'b0, 16'h0000, 16'h0000, 10'h000, 16'hAAAA, 16'hBEEF};
    vecs[9]  = '{1'b1, 16'h0020, 16'h1111, 10'h000, 16'h0000, 16'hBEEF};
    vecs[10] = '{1'b1, 16'h00FF, 16'h7777, 10'h000, 16'h0000, 16'hBEEF};
    vecs[11] = '{1'b0, 16'h00FF, 16'h0000, 10'h000, 16'h7777, 16'hBEEF};
    vecs[12] = '{1'b0, 16'h0100, 16'h0000, 10'h1FF, 16'h0000, 16'hBEEF};
    vecs[13] = '{1'b1, 16'h0100, 16'h9999, 10'h000, 16'h0000, 16'hBEEF};
    vecs[14] = '{1'b0, 16'h0000, 16'h0000, 10'h000, 16'hAAAA, 16'hBEEF};

    ops[0] = '{1'b1, 16'h0001, 16'hA1A1};
    ops[1] = '{1'b1, 16'h0002, 16'hB2B2};
    ops[2] = '{1'b0, 16'h0001, 16'hA1A1};
    ops[3] = '{1'b0, 16'h0002, 16'hB2B2};

    repeat (3) @(negedge clk);
    Reset = 1'b0;
    @(negedge clk);
    chk("reset_rdy",   {31'd0, mem_rdy}, 32'd0);
    chk("reset_rdata", {16'h0000, mem_rdata}, 32'd0);
    chk("reset_hex",   {16'h0000, hex_data}, 32'd0);
    chk("reset_err",   {31'd0, err}, 32'd0);
    chk("reset_rdy0",  {31'd0, rdy0}, 32'd0);

    for (int i = 0; i < 15; i++) begin
      xfer(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].sw, vecs[i].exp_rdata, vecs[i].exp_hex);
    end
    chk("err_clean_traffic", {31'd0, err}, 32'd0);

    // Address changes mid-wait: flagged, but the captured write still lands at x0030.
    mem_we = 1'b1; mem_addr = 16'h0030; mem_wdata = 16'hC0DE; mem_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_addr = 16'h0031;
    @(negedge clk);
    @(negedge clk);
    chk("chg_rdy", {31'd0, mem_rdy}, 32'd1);
    chk("chg_err", {31'd0, err}, 32'd1);
    @(posedge clk); #1;
    mem_req = 1'b0;
    @(negedge clk);
    xfer(1'b0, 16'h0030, 16'h0000, 10'h000, 16'hC0DE, 16'hBEEF);
    do_reset();
    chk("reset_clears_err", {31'd0, err}, 32'd0);
    chk("reset_clears_hex", {16'h0000, hex_data}, 32'd0);

    // Abort a write to x0020 in WAIT: no pulse, err set, RAM untouched.
    mem_we = 1'b1; mem_addr = 16'h0020; mem_wdata = 16'h2222; mem_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_req = 1'b0;
    rdy_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (mem_rdy) rdy_cnt++;
    end
    chk("abort_no_rdy", rdy_cnt, 0);
    chk("abort_err", {31'd0, err}, 32'd1);
    xfer(1'b0, 16'h0020, 16'h0000, 10'h000, 16'h1111, 16'h0000);
    chk("err_sticky", {31'd0, err}, 32'd1);
    do_reset();
    chk("err_cleared", {31'd0, err}, 32'd0);

    // Reset during WAIT: back in IDLE with no response.
    mem_we = 1'b0; mem_addr = 16'h0010; mem_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Reset = 1'b1; mem_req = 1'b0;
    @(negedge clk);
    chk("rst_wait_rdy", {31'd0, mem_rdy}, 32'd0);
    Reset = 1'b0;
    @(negedge clk);
    chk("rst_wait_rdy_late", {31'd0, mem_rdy}, 32'd0);
    @(negedge clk);
    chk("rst_wait_rdy_later", {31'd0, mem_rdy}, 32'd0);

    // Reset on the edge leaving RESP discards the pending write.
    mem_we = 1'b1; mem_addr = 16'h0010; mem_wdata = 16'h5A5A; mem_req = 1'b1;
    @(posedge clk);
    repeat (3) @(negedge clk);
    chk("rst_resp_rdy", {31'd0, mem_rdy}, 32'd1);
    Reset = 1'b1; mem_req = 1'b0;
    @(negedge clk);
    Reset = 1'b0;
    @(negedge clk);
    xfer(1'b0, 16'h0010, 16'h0000, 10'h000, 16'h1234, 16'h0000);

    // Zero wait states, mem_req held across four transfers: pulses two cycles apart.
    we0 = ops[0].we; addr0 = ops[0].addr; wdata0 = ops[0].data; req0 = 1'b1;
    n = 0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      if (rdy0) begin
        if (n < 4) begin
          chk("b2b_slot", cyc, 2 * n + 1);
          if (!ops[n].we) chk("b2b_rdata", {16'h0000, rdata0}, {16'h0000, ops[n].data});
        end else begin
          chk("b2b_extra_rdy", {31'd0, rdy0}, 32'd0);
        end
        n++;
        @(posedge clk); #1;
        if (n < 4) begin
          we0 = ops[n].we; addr0 = ops[n].addr; wdata0 = ops[n].data;
        end else begin
          req0 = 1'b0;
        end
      end
    end
    chk("b2b_count", n, 4);
    chk("b2b_err", {31'd0, err0}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
